// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for a small MIPS-like core: sequences fetch, decode,
// execute, memory and writeback, with handshake timeouts and a retire counter.
module multi_cycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_en,
  output logic             pc_en,
  output logic             branch,
  output logic             cond,
  output logic             jal,
  output logic [1:0]       jump,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             link_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  localparam int WAIT_W = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);
  localparam logic [WAIT_W-1:0] TMO_CNT = WAIT_W'(MEM_TMO);

  logic [2:0]       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic is_r, r_add, r_sub, r_slt, r_jr;
  logic is_lw, is_sw, is_beq, is_bne, is_addi, is_xori, is_j, is_jal;
  logic legal, tmo;
  logic [2:0] arith_op;

  assign is_r    = (op_q == OP_R);
  assign r_add   = is_r && (funct_q == F_ADD);
  assign r_sub   = is_r && (funct_q == F_SUB);
  assign r_slt   = is_r && (funct_q == F_SLT);
  assign r_jr    = is_r && (funct_q == F_JR);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_beq  = (op_q == OP_BEQ);
  assign is_bne  = (op_q == OP_BNE);
  assign is_addi = (op_q == OP_ADDI);
  assign is_xori = (op_q == OP_XORI);
  assign is_j    = (op_q == OP_J);
  assign is_jal  = (op_q == OP_JAL);
  assign legal   = r_add || r_sub || r_slt || r_jr || is_lw || is_sw || is_beq ||
                   is_bne || is_addi || is_xori || is_j || is_jal;
  assign tmo     = (wait_q == TMO_CNT);

  always_comb begin
    arith_op = ALU_ADD;
    if (r_sub)        arith_op = ALU_SUB;
    else if (r_slt)   arith_op = ALU_SLT;
    else if (is_xori) arith_op = ALU_XOR;
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q + WAIT_W'(1);
    op_d       = op_q;
    funct_d    = funct_q;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    branch     = 1'b0;
    cond       = 1'b0;
    jal        = 1'b0;
    jump       = 2'b00;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    link_we    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    err        = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (tmo) begin
          // Request dropped for one cycle; re-entering FETCH restarts the wait count.
          err     = 1'b1;
          wait_d  = '0;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            // ir_en is handshake-gated, so it must also be held off during reset.
            ir_en   = rst_n;
            op_d    = op;
            funct_d = funct;
            state_d = S_DECODE;
            wait_d  = '0;
          end
        end
      end
      S_DECODE: begin
        wait_d = '0;
        if (is_j || is_jal) begin
          pc_en   = 1'b1;
          jump    = 2'b10;
          jal     = is_jal;
          link_we = is_jal;
          state_d = S_FETCH;
        end else if (r_jr) begin
          pc_en   = 1'b1;
          jump    = 2'b01;
          state_d = S_FETCH;
        end else if (!legal) begin
          err     = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_beq || is_bne) begin
          alu_op  = ALU_SUB;
          branch  = 1'b1;
          cond    = is_beq ? zero : ~zero;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          alu_op  = ALU_ADD;
          state_d = S_MEM;
        end else begin
          alu_op  = arith_op;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (tmo) begin
          err     = 1'b1;
          wait_d  = '0;
          state_d = S_FETCH;
        end else begin
          mem_re = is_lw;
          mem_we = is_sw;
          if (dmem_ready) begin
            wait_d = '0;
            if (is_lw) begin
              state_d = S_WB;
            end else begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_WB: begin
        wait_d     = '0;
        reg_we     = 1'b1;
        mem_to_reg = is_lw;
        pc_en      = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end
    endcase

    instr_count_d = instr_count_q + CNT_W'(pc_en);
  end

  assign instr_count = instr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      op_q          <= '0;
      funct_q       <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      op_q          <= op_d;
      funct_q       <= funct_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Parameter MEM_TMO, default 15, maximum wait cycles on any memory handshake before error.
REQ-003 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port op  in  6  opcode field of the instruction word on the fetch data bus.
REQ-006 Port funct  in  6  funct field of the same word.
REQ-007 Port zero  in  1  ALU zero flag from the datapath.
REQ-008 Port imem_ready  in  1  instruction memory data valid.
REQ-009 Port dmem_ready  in  1  data memory access complete.
REQ-010 Port imem_req  out  1  instruction read request.
REQ-011 Port ir_en  out  1  instruction register load strobe.
REQ-012 Port pc_en  out  1  PC update strobe to the fetch unit.
REQ-013 Port branch  out  1  branch select to the fetch unit.
REQ-014 Port cond  out  1  branch condition to the fetch unit's zero input.
REQ-015 Port jal  out  1  link-offset select to the fetch unit.
REQ-016 Port jump  out  2  next-PC select: 00 sequential/branch, 01 register (JR), 10 target.
REQ-017 Port alu_op  out  3  000 add, 001 sub, 010 slt, 011 xor.
REQ-018 Port reg_we  out  1  register file write enable.
REQ-019 Port link_we  out  1  write PC+1 to r31 (JAL).
REQ-020 Port mem_re / mem_we  out  1 each  data memory read / write request.
REQ-021 Port mem_to_reg  out  1  writeback source is load data.
REQ-022 Port err  out  1  one-cycle pulse: illegal opcode or memory timeout.
REQ-023 Port instr_count  out  CNT_W  retired-instruction count.

Function
REQ-024 States SHALL be FETCH, DECODE, EXEC, MEM, WB; encoding is free.
REQ-025 FETCH: imem_req=1; on imem_ready, latch op/funct internally, pulse ir_en, go to DECODE; else hold.
REQ-026 Decoded set: R-type op 000000 (funct 100000 add, 100010 sub, 101010 slt, 001000 JR), LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, XORI 001110, J 000010, JAL 000011.
REQ-027 DECODE: J -> pc_en, jump=10, go to FETCH; JAL -> pc_en, jump=10, jal=1, link_we=1, go to FETCH; JR -> pc_en, jump=01, go to FETCH; other legal ops -> EXEC.
REQ-028 Illegal op or R-type funct SHALL in DECODE pulse err, pulse pc_en with jump=00 and branch=0 (skip), go to FETCH.
REQ-029 EXEC: BEQ/BNE -> alu_op=sub, branch=1, cond=zero (BEQ) or ~zero (BNE), pc_en, go to FETCH; LW/SW -> alu_op=add, go to MEM; arithmetic -> per REQ-017, go to WB.
REQ-030 MEM: LW asserts mem_re, SW asserts mem_we, until dmem_ready; on dmem_ready LW -> WB, SW -> pc_en, go to FETCH.
REQ-031 WB: reg_we=1, mem_to_reg=1 only for LW, pc_en, go to FETCH; one cycle.
REQ-032 pc_en SHALL assert exactly once per instruction, in its final cycle; all unnamed outputs are 0 in every state.
REQ-033 Outputs SHALL be functions of state and latched op/funct only, except cond (zero) and the handshake-gated strobes.
REQ-034 A wait counter SHALL clear on each state entry; if imem_ready or dmem_ready is absent for MEM_TMO consecutive cycles, pulse err, deassert request, return to FETCH without pc_en.
REQ-035 instr_count SHALL increment by 1 on every pc_en cycle, wrap modulo 2^CNT_W, not count timeouts.
REQ-036 Minimum latency: J/JAL/JR 2 cycles, branch 3, ALU 4, SW 4, LW 5 (zero-wait memory).

Reset
REQ-037 rst_n low SHALL immediately force FETCH, clear wait counter, latched op/funct and instr_count, and drive every output to 0 except imem_req.
REQ-038 imem_req SHALL assert in the first clk cycle after rst_n deasserts; reset mid-instruction abandons it with no pc_en.

Verification
REQ-039 ADD (op 0, funct 100000), zero-wait -> FETCH,DECODE,EXEC,WB; reg_we and pc_en in cycle 4; instr_count 0->1.
REQ-040 BNE with zero=1 -> EXEC branch=1, cond=0, pc_en=1; BEQ with zero=1 -> cond=1.
REQ-041 LW with dmem_ready delayed 3 cycles -> mem_re held 4 cycles, then WB with mem_to_reg=1, reg_we=1.
REQ-042 JAL -> cycle 2 pc_en=1, jump=10, jal=1, link_we=1; op 111111 -> cycle 2 err=1, pc_en=1, jump=00.
REQ-043 imem_ready held low 15 cycles -> err pulse, no pc_en, instr_count unchanged, FETCH restarts.
REQ-044 rst_n low during MEM of SW -> mem_we drops asynchronously; after release FETCH, instr_count=0.
